// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer.
// Holds the byte type, the issue FSM state encoding and the default FIFO depth.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_fifo_state_e;

  localparam int UART_TX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 register array with wrapping write and read pointers.
// Occupancy is tracked by the owner; this block only stores bytes and
// presents the entry at the read pointer combinationally.
module sync_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       clear,
  output logic [7:0] rd_data
);

  uart_byte_t        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage: entries are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers: a clear drops everything queued by catching the reader up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue controller feeding a UART transmitter.
// Bytes arrive on a valid/ready port and leave one at a time as a single
// uart_tx_en pulse, paced by uart_tx_busy.
// Optional macro UART_TX_FIFO_FLUSH_EN adds a 'flush' input that discards
// all queued bytes without disturbing a transfer already handed to the UART.
module uart_tx_fifo import uart_pkg::*; #(
  parameter  int DEPTH  = UART_TX_FIFO_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            uart_tx_en,
  output logic [7:0]      uart_tx_data,
  input  logic            uart_tx_busy,
  output logic            idle
`ifdef UART_TX_FIFO_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  tx_fifo_state_e state;
  tx_fifo_state_e state_next;
  logic           flush_req;
  logic           push;
  logic           pop;
  logic           start;
  logic [7:0]     head;
  logic [7:0]     data_q;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Ready depends only on the registered level, so a same-cycle pop never
  // opens the door while full.
  assign in_ready = (level != FULL_LEVEL);
  assign empty    = (level == '0);
  assign push     = in_valid && in_ready && !flush_req;
  assign pop      = (state == ISSUE);
  assign start    = (state == IDLE) && (state_next == ISSUE);

  sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .clear   (flush_req),
    .rd_data (head)
  );

  // Occupancy: push and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset || flush_req) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + (ADDR_W + 1)'(1);
    end else if (pop && !push) begin
      level <= level - (ADDR_W + 1)'(1);
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: issue only when the UART is free, then follow one full busy window.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!empty && !uart_tx_busy && !flush_req) state_next = ISSUE;
      ISSUE:     state_next = uart_tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Capture the head byte as the FSM enters ISSUE; it is held until the next issue.
  always_ff @(posedge clk) begin
    if (!reset)     data_q <= 8'h00;
    else if (start) data_q <= head;
  end

  assign uart_tx_en   = (state == ISSUE);
  assign uart_tx_data = data_q;
  assign idle         = empty && (state == IDLE) && !uart_tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-based model
// of the buffer and the UART handshake.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] level;
  logic       empty;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       idle;
  logic       flush_drv;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] q[$];
  logic       expect_en;
  logic       pending;
  logic       seen_busy;
  logic [7:0] last_data;
  logic       last_accepted;
  logic       force_busy;
  int         en_count;
  int         busy_cnt;
  int         busy_len;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .level        (level),
    .empty        (empty),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .idle         (idle)
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    .flush        (flush_drv)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then let the UART model react just after it.
  task automatic runCycle();
    logic       en_s, busy_s, valid_s, flush_s, reset_s;
    logic [7:0] din_s;
    logic [7:0] exp_data;
    int         sz;
    @(negedge clk);
    exp_data = last_data;
    if (expect_en && q.size() > 0) exp_data = q[0];
    checkOutput("level", 32'(level), 32'(q.size()));
    checkOutput("empty", 32'(empty), 32'(q.size() == 0));
    checkOutput("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    checkOutput("uart_tx_en", 32'(uart_tx_en), 32'(expect_en));
    checkOutput("uart_tx_data", 32'(uart_tx_data), 32'(exp_data));
    checkOutput("idle", 32'(idle), 32'(q.size() == 0 && !pending && !expect_en && !uart_tx_busy));
    if (uart_tx_en) begin
      checkOutput("en_while_busy", 32'(uart_tx_busy), 32'(0));
      checkOutput("en_outstanding", 32'(pending), 32'(0));
    end
    en_s    = uart_tx_en;
    busy_s  = uart_tx_busy;
    valid_s = in_valid;
    din_s   = in_data;
    flush_s = flush_drv;
    reset_s = reset;
    @(posedge clk);
    sz = q.size();
    last_accepted = 1'b0;
    if (!reset_s) begin
      q.delete();
      expect_en = 1'b0;
      pending   = 1'b0;
      seen_busy = 1'b0;
      last_data = 8'h00;
    end else begin
      if (expect_en) begin
        if (q.size() > 0) begin
          last_data = q[0];
          void'(q.pop_front());
        end
        expect_en = 1'b0;
        pending   = 1'b1;
        seen_busy = busy_s;
      end else if (pending) begin
        if (busy_s)         seen_busy = 1'b1;
        else if (seen_busy) pending   = 1'b0;
      end else if (sz > 0 && !busy_s && !flush_s) begin
        expect_en = 1'b1;
      end
      if (flush_s) begin
        q.delete();
      end else if (valid_s && sz < DEPTH) begin
        q.push_back(din_s);
        last_accepted = 1'b1;
      end
    end
    #1;
    if (en_s) begin
      en_count++;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    in_valid = valid;
    in_data  = data;
    runCycle();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || pending || expect_en || busy_cnt != 0) && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput(tag, 32'(n < budget), 32'(1));
  endtask

  initial begin
    int start;
    int n;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; uart_tx_busy = 1'b0;
    flush_drv = 1'b0; force_busy = 1'b0; busy_cnt = 0; busy_len = 10;
    expect_en = 1'b0; pending = 1'b0; seen_busy = 1'b0; last_data = 8'h00;
    last_accepted = 1'b0; en_count = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("rst_level", 32'(level), 32'(0));
    checkOutput("rst_empty", 32'(empty), 32'(1));
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_en", 32'(uart_tx_en), 32'(0));
    checkOutput("rst_data", 32'(uart_tx_data), 32'(0));
    checkOutput("rst_idle", 32'(idle), 32'(1));

    // single byte, UART idle: pulse two cycles after the push is presented
    busy_len = 10;
    start = en_count;
    applyStimulus(1'b1, 8'hA5);
    in_valid = 1'b0;
    n = 0;
    while (en_count == start && n < 10) begin
      runCycle();
      n++;
    end
    checkOutput("single_latency", 32'(n), 32'(2));
    checkOutput("single_data", 32'(uart_tx_data), 32'(8'hA5));
    repeat (14) runCycle();
    checkOutput("single_one_pulse", 32'(en_count - start), 32'(1));
    checkOutput("single_idle", 32'(idle), 32'(1));

    // burst of 16 bytes, in order, one pulse per busy window
    busy_len = 3;
    start = en_count;
    for (int i = 1; i <= 16; i++) begin
      n = 0;
      do begin
        applyStimulus(1'b1, 8'(i));
        n++;
      end while (!last_accepted && n < 50);
    end
    drain("burst_drain", 500);
    checkOutput("burst_pulses", 32'(en_count - start), 32'(16));

    // full backpressure: UART held busy, 20 pushes offered
    force_busy = 1'b1;
    in_valid = 1'b0;
    runCycle();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h20 + i));
    in_valid = 1'b0;
    checkOutput("full_level", 32'(level), 32'(16));
    checkOutput("full_in_ready", 32'(in_ready), 32'(0));
    start = en_count;
    force_busy = 1'b0;
    drain("full_drain", 800);
    checkOutput("full_drain_count", 32'(en_count - start), 32'(16));

    // simultaneous push and pop at level 3
    force_busy = 1'b1;
    runCycle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h31 + i));
    in_valid = 1'b0;
    force_busy = 1'b0;
    n = 0;
    while (!expect_en && n < 10) begin
      runCycle();
      n++;
    end
    checkOutput("simul_issue_seen", 32'(expect_en), 32'(1));
    applyStimulus(1'b1, 8'h34);
    in_valid = 1'b0;
    checkOutput("simul_level", 32'(level), 32'(3));
    drain("simul_drain", 300);

    // reset mid-transfer with level 5 and the UART still busy
    busy_len = 20;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i));
    in_valid = 1'b0;
    checkOutput("pre_reset_level", 32'(level), 32'(5));
    reset = 1'b0;
    runCycle();
    reset = 1'b1;
    checkOutput("post_reset_level", 32'(level), 32'(0));
    checkOutput("post_reset_empty", 32'(empty), 32'(1));
    checkOutput("post_reset_en", 32'(uart_tx_en), 32'(0));
    start = en_count;
    applyStimulus(1'b1, 8'h77);
    in_valid = 1'b0;
    n = 0;
    while (uart_tx_busy && n < 40) begin
      runCycle();
      n++;
    end
    checkOutput("post_reset_no_pulse", 32'(en_count - start), 32'(0));
    drain("post_reset_drain", 200);
    checkOutput("post_reset_pulse", 32'(en_count - start), 32'(1));

`ifdef UART_TX_FIFO_FLUSH_EN
    // flush with a push in the same cycle while a byte is in flight
    busy_len = 10;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h50 + i));
    checkOutput("pre_flush_level", 32'(level), 32'(6));
    flush_drv = 1'b1;
    applyStimulus(1'b1, 8'hEE);
    flush_drv = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_level", 32'(level), 32'(0));
    start = en_count;
    repeat (25) runCycle();
    checkOutput("flush_no_pulse", 32'(en_count - start), 32'(0));
    checkOutput("flush_idle", 32'(idle), 32'(1));
`endif

    // randomised traffic with varying UART busy windows
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      busy_len = $urandom_range(1, 6);
`ifdef UART_TX_FIFO_FLUSH_EN
      flush_drv = ($urandom_range(0, 39) == 0);
`endif
      runCycle();
    end
    flush_drv = 1'b0;
    drain("random_drain", 800);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
